// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arb
// Description : Round-robin arbiter sharing one adder between two requesters,
//               each with a registered one-entry response slot.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic [WIDTH-1:0] a_rsp_sum,
    output logic             a_rsp_carry,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] b_rsp_sum,
    output logic             b_rsp_carry,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    slot_state_t      r_a_state;
    slot_state_t      r_b_state;
    logic             r_last_b;
    logic [WIDTH-1:0] r_a_sum;
    logic [WIDTH-1:0] r_b_sum;
    logic             r_a_carry;
    logic             r_b_carry;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    logic             w_a_elig;
    logic             w_b_elig;
    logic             w_a_grant;
    logic             w_b_grant;
    logic [WIDTH-1:0] w_add_op1;
    logic [WIDTH-1:0] w_add_op2;
    logic [WIDTH:0]   w_add_sum;

    // A full slot whose consumer drains this cycle can be refilled in the same cycle.
    assign w_a_elig  = a_req_valid && ((r_a_state == SLOT_EMPTY) || a_rsp_ready);
    assign w_b_elig  = b_req_valid && ((r_b_state == SLOT_EMPTY) || b_rsp_ready);
    assign w_a_grant = w_a_elig && (!w_b_elig || r_last_b);
    assign w_b_grant = w_b_elig && !w_a_grant;

    assign w_add_op1 = w_a_grant ? a_op1 : b_op1;
    assign w_add_op2 = w_a_grant ? a_op2 : b_op2;
    assign w_add_sum = {1'b0, w_add_op1} + {1'b0, w_add_op2};

    // Flops never see the gated grant; reset_n only masks the handshake outputs.
    assign a_req_ready = w_a_grant & reset_n;
    assign b_req_ready = w_b_grant & reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_state <= SLOT_EMPTY;
            r_b_state <= SLOT_EMPTY;
            r_last_b  <= 1'b1;
            r_a_sum   <= '0;
            r_b_sum   <= '0;
            r_a_carry <= 1'b0;
            r_b_carry <= 1'b0;
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_a_grant) begin
                r_a_state <= SLOT_FULL;
                r_a_sum   <= w_add_sum[WIDTH-1:0];
                r_a_carry <= w_add_sum[WIDTH];
                r_last_b  <= 1'b0;
                if (r_a_count != C_CNT_MAX) begin
                    r_a_count <= r_a_count + 1'b1;
                end
            end else if ((r_a_state == SLOT_FULL) && a_rsp_ready) begin
                r_a_state <= SLOT_EMPTY;
            end

            if (w_b_grant) begin
                r_b_state <= SLOT_FULL;
                r_b_sum   <= w_add_sum[WIDTH-1:0];
                r_b_carry <= w_add_sum[WIDTH];
                r_last_b  <= 1'b1;
                if (r_b_count != C_CNT_MAX) begin
                    r_b_count <= r_b_count + 1'b1;
                end
            end else if ((r_b_state == SLOT_FULL) && b_rsp_ready) begin
                r_b_state <= SLOT_EMPTY;
            end
        end
    end

    assign a_rsp_valid = (r_a_state == SLOT_FULL);
    assign b_rsp_valid = (r_b_state == SLOT_FULL);
    assign a_rsp_sum   = r_a_sum;
    assign b_rsp_sum   = r_b_sum;
    assign a_rsp_carry = r_a_carry;
    assign b_rsp_carry = r_b_carry;
    assign a_count     = r_a_count;
    assign b_count     = r_b_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arb
// Description : Directed bench for adder_share_arb with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arb;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_req_valid = 0, b_req_valid = 0;
    logic       a_req_ready, b_req_ready;
    logic [7:0] a_op1 = 0, a_op2 = 0, b_op1 = 0, b_op2 = 0;
    logic       a_rsp_valid, b_rsp_valid;
    logic       a_rsp_ready = 0, b_rsp_ready = 0;
    logic [7:0] a_rsp_sum, b_rsp_sum;
    logic       a_rsp_carry, b_rsp_carry;
    logic [15:0] a_count, b_count;

    logic       s_a_req_valid = 0, s_b_req_valid = 0;
    logic       s_a_req_ready, s_b_req_ready;
    logic [7:0] s_a_op1 = 0, s_a_op2 = 0, s_b_op1 = 0, s_b_op2 = 0;
    logic       s_a_rsp_valid, s_b_rsp_valid;
    logic       s_a_rsp_ready = 0, s_b_rsp_ready = 0;
    logic [7:0] s_a_rsp_sum, s_b_rsp_sum;
    logic       s_a_rsp_carry, s_b_rsp_carry;
    logic [1:0] s_a_count, s_b_count;

    int tests = 0;
    int errors = 0;

    always #5 clock = ~clock;

    adder_share_arb #(.WIDTH(8), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_op1(a_op1), .a_op2(a_op2),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_sum(a_rsp_sum), .a_rsp_carry(a_rsp_carry),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_op1(b_op1), .b_op2(b_op2),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_sum(b_rsp_sum), .b_rsp_carry(b_rsp_carry),
        .a_count(a_count), .b_count(b_count)
    );

    adder_share_arb #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(s_a_req_valid), .a_req_ready(s_a_req_ready),
        .a_op1(s_a_op1), .a_op2(s_a_op2),
        .a_rsp_valid(s_a_rsp_valid), .a_rsp_ready(s_a_rsp_ready),
        .a_rsp_sum(s_a_rsp_sum), .a_rsp_carry(s_a_rsp_carry),
        .b_req_valid(s_b_req_valid), .b_req_ready(s_b_req_ready),
        .b_op1(s_b_op1), .b_op2(s_b_op2),
        .b_rsp_valid(s_b_rsp_valid), .b_rsp_ready(s_b_rsp_ready),
        .b_rsp_sum(s_b_rsp_sum), .b_rsp_carry(s_b_rsp_carry),
        .a_count(s_a_count), .b_count(s_b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-port slot contents and counts, plus who won last.
    int m_valid[2];
    int m_sum[2];
    int m_carry[2];
    int m_count[2];
    int m_last;

    function automatic int model_grant();
        bit ea, eb;
        ea = a_req_valid && (m_valid[0] == 0 || a_rsp_ready);
        eb = b_req_valid && (m_valid[1] == 0 || b_rsp_ready);
        if (ea && eb) return (m_last == 1) ? 0 : 1;
        if (ea) return 0;
        if (eb) return 1;
        return -1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int g, total;
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                m_valid[p] = 0; m_sum[p] = 0; m_carry[p] = 0; m_count[p] = 0;
            end
            m_last = 1;
        end else begin
            g = model_grant();
            if (g != 0 && m_valid[0] == 1 && a_rsp_ready) m_valid[0] = 0;
            if (g != 1 && m_valid[1] == 1 && b_rsp_ready) m_valid[1] = 0;
            if (g >= 0) begin
                total = (g == 0) ? int'(a_op1) + int'(a_op2) : int'(b_op1) + int'(b_op2);
                m_valid[g] = 1;
                m_sum[g]   = total % 256;
                m_carry[g] = (total >= 256) ? 1 : 0;
                if (m_count[g] < 65535) m_count[g] = m_count[g] + 1;
                m_last = g;
            end
        end
    end

    always @(negedge clock) begin
        int g;
        if (!reset_n) begin
            chk("rst_a_req_ready", a_req_ready, 0);
            chk("rst_b_req_ready", b_req_ready, 0);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
        end else begin
            g = model_grant();
            chk("a_req_ready", a_req_ready, (g == 0) ? 1 : 0);
            chk("b_req_ready", b_req_ready, (g == 1) ? 1 : 0);
        end
        chk("a_rsp_valid", a_rsp_valid, m_valid[0]);
        chk("b_rsp_valid", b_rsp_valid, m_valid[1]);
        chk("a_rsp_sum", a_rsp_sum, m_sum[0]);
        chk("b_rsp_sum", b_rsp_sum, m_sum[1]);
        chk("a_rsp_carry", a_rsp_carry, m_carry[0]);
        chk("b_rsp_carry", b_rsp_carry, m_carry[1]);
        chk("a_count", a_count, m_count[0]);
        chk("b_count", b_count, m_count[1]);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] edge_op1 [3] = '{8'd255, 8'd0, 8'd255};
    logic [7:0] edge_op2 [3] = '{8'd1,   8'd0, 8'd255};
    int         edge_sum [3] = '{0, 0, 254};
    int         edge_cy  [3] = '{1, 0, 1};

    initial begin
        // Reset then idle
        repeat (3) step();
        chk("reset_a_count", a_count, 0);
        chk("reset_b_sum", b_rsp_sum, 0);
        reset_n = 1'b1;
        step();

        // Single A op: 200 + 100
        a_req_valid = 1; a_op1 = 8'd200; a_op2 = 8'd100; a_rsp_ready = 1;
        #1 chk("single_a_ready", a_req_ready, 1);
        step();
        a_req_valid = 0;
        #1;
        chk("single_a_valid", a_rsp_valid, 1);
        chk("single_a_sum", a_rsp_sum, 44);
        chk("single_a_carry", a_rsp_carry, 1);
        chk("single_a_count", a_count, 1);

        // Edge arithmetic on B, back-to-back
        b_rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b_req_valid = 1; b_op1 = edge_op1[i]; b_op2 = edge_op2[i];
            #1 chk("edge_b_ready", b_req_ready, 1);
            step();
            chk("edge_b_valid", b_rsp_valid, 1);
            chk("edge_b_sum", b_rsp_sum, edge_sum[i]);
            chk("edge_b_carry", b_rsp_carry, edge_cy[i]);
        end
        b_req_valid = 0;
        chk("edge_b_count", b_count, 3);

        // Backpressure: B holds a result while A takes every cycle
        b_req_valid = 1; b_op1 = 8'd10; b_op2 = 8'd20;
        step();
        b_rsp_ready = 0; b_op1 = 8'd5; b_op2 = 8'd6;
        a_req_valid = 1; a_rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            a_op1 = 8'(k); a_op2 = 8'(k);
            #1;
            chk("bp_a_ready", a_req_ready, 1);
            chk("bp_b_ready", b_req_ready, 0);
            chk("bp_b_sum_hold", b_rsp_sum, 30);
            step();
        end
        b_rsp_ready = 1;
        #1;
        chk("refill_b_ready", b_req_ready, 1);
        chk("refill_a_ready", a_req_ready, 0);
        step();
        chk("refill_b_valid", b_rsp_valid, 1);
        chk("refill_b_sum", b_rsp_sum, 11);

        // Fill both slots, then reset mid-run
        a_rsp_ready = 0; b_rsp_ready = 0;
        step();
        chk("full_a_valid", a_rsp_valid, 1);
        chk("full_b_valid", b_rsp_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_a_valid", a_rsp_valid, 0);
        chk("async_b_valid", b_rsp_valid, 0);
        chk("async_a_sum", a_rsp_sum, 0);
        chk("async_b_count", b_count, 0);
        chk("async_a_count", a_count, 0);
        chk("async_a_ready", a_req_ready, 0);
        a_req_valid = 0; b_req_valid = 0;
        step();
        step();
        reset_n = 1'b1;

        // Contention: strict alternation starting with A
        a_rsp_ready = 1; b_rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            a_req_valid = 1; a_op1 = 8'(i); a_op2 = 8'd1;
            b_req_valid = 1; b_op1 = 8'(i); b_op2 = 8'd2;
            #1;
            chk("cont_a_ready", a_req_ready, (i % 2 == 0) ? 1 : 0);
            chk("cont_b_ready", b_req_ready, (i % 2 == 1) ? 1 : 0);
            step();
            if (i % 2 == 0) chk("cont_a_sum", a_rsp_sum, i + 1);
            else            chk("cont_b_sum", b_rsp_sum, i + 2);
        end
        a_req_valid = 0; b_req_valid = 0;
        chk("cont_a_count", a_count, 3);
        chk("cont_b_count", b_count, 3);

        // Counter saturation on the 2-bit instance
        s_a_req_valid = 1; s_a_op1 = 8'd3; s_a_op2 = 8'd4; s_a_rsp_ready = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sat_a_count", s_a_count, (k + 1 > 3) ? 3 : k + 1);
        end
        s_a_req_valid = 0;
        chk("sat_a_sum", s_a_rsp_sum, 7);
        chk("sat_b_count", s_b_count, 0);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
